spi_cmd_sched: RTL and testbench

- Command sequencer behind spi_slave. Consumes each received 32-bit word (rx word + one-cycle ready pulse) and decodes it into register write and read transactions on a shared parameter bus.
- Drives the parameter bus with a req/ack handshake and a timeout.
- Returns read data and status as the tx word that spi_slave shifts out on MISO in the next frame.

---
 rtl/spi_cmd_pkg.sv | 26 ++
 rtl/spi_cmd_sched_sat_counter.sv | 19 +
 rtl/spi_cmd_sched.sv | 156 +++++++++++++++
 tb/tb_spi_cmd_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared opcodes, FSM encoding and header layout for spi_cmd_sched
package spi_cmd_pkg;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_WR_IMM  = 4'h1;
    localparam logic [3:0] OP_WR_LONG = 4'h2;
    localparam logic [3:0] OP_RD      = 4'h3;
    localparam logic [3:0] OP_STATUS  = 4'hF;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DATA = 2'd1;
    localparam logic [1:0] ST_ISSUE     = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd3;

    localparam int HDR_OP_LSB   = 28;
    localparam int HDR_ADDR_LSB = 20;
    localparam int HDR_IMM_W    = 20;

    localparam logic [31:0] TIMEOUT_MARK = 32'hDEAD_0000;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_WR_IMM) || (op == OP_WR_LONG) ||
               (op == OP_RD) || (op == OP_STATUS);
    endfunction

endpackage

// File: rtl/spi_cmd_sched_sat_counter.sv
// rtl/spi_cmd_sched_sat_counter.sv - saturating event counter, cleared only by reset
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (inc && (value != {CNT_W{1'b1}})) begin
            value <= value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/spi_cmd_sched.sv
// rtl/spi_cmd_sched.sv - SPI word command sequencer driving a req/ack parameter bus
// Optional write echo into tx_word when SPI_CMD_ECHO_EN is defined.
module spi_cmd_sched
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       rx_word,
    input  logic              rx_rdy,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic [31:0]       tx_word,
    output logic              busy,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  ovr_cnt
);

    // Last timer value before abort: WAIT_ACK lasts exactly TIMEOUT cycles.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] timer;
    logic [3:0]  opcode;
    logic        ack;
    logic        timed_out;
    logic        err_inc;
    logic        ovr_inc;
    logic [7:0]  err8;
    logic [7:0]  ovr8;
`ifdef SPI_CMD_ECHO_EN
    logic [31:0] hdr;
`endif

    assign opcode    = rx_word[HDR_OP_LSB +: 4];
    assign ack       = bus_ack & bus_req;
    assign timed_out = (state == ST_WAIT_ACK) && !ack && (timer == TIMER_LAST);
    assign busy      = (state != ST_IDLE);
    assign err8      = 8'(err_cnt);
    assign ovr8      = 8'(ovr_cnt);

    always_comb begin
        err_inc = 1'b0;
        ovr_inc = 1'b0;
        if (state == ST_IDLE) begin
            err_inc = rx_rdy && !op_is_legal(opcode);
        end else if (state == ST_ISSUE || state == ST_WAIT_ACK) begin
            ovr_inc = rx_rdy;
            err_inc = timed_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            tx_word   <= '0;
`ifdef SPI_CMD_ECHO_EN
            hdr       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_rdy) begin
                        case (opcode)
                            OP_WR_IMM: begin
                                bus_addr  <= rx_word[HDR_ADDR_LSB +: ADDR_W];
                                bus_we    <= 1'b1;
                                bus_wdata <= {12'h000, rx_word[HDR_IMM_W-1:0]};
                                state     <= ST_ISSUE;
`ifdef SPI_CMD_ECHO_EN
                                hdr       <= rx_word;
`endif
                            end
                            OP_WR_LONG: begin
                                bus_addr <= rx_word[HDR_ADDR_LSB +: ADDR_W];
                                bus_we   <= 1'b1;
                                state    <= ST_WAIT_DATA;
`ifdef SPI_CMD_ECHO_EN
                                hdr      <= rx_word;
`endif
                            end
                            OP_RD: begin
                                bus_addr <= rx_word[HDR_ADDR_LSB +: ADDR_W];
                                bus_we   <= 1'b0;
                                state    <= ST_ISSUE;
                            end
                            OP_STATUS: begin
                                tx_word <= {busy, 7'h00, 8'h00, ovr8, err8};
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WAIT_DATA: begin
                    if (rx_rdy) begin
                        bus_wdata <= rx_word;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    bus_req <= 1'b1;
                    timer   <= '0;
                    state   <= ST_WAIT_ACK;
                end
                default: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (ack) begin
                        bus_req <= 1'b0;
                        state   <= ST_IDLE;
                        if (!bus_we) begin
                            tx_word <= bus_rdata;
                        end
`ifdef SPI_CMD_ECHO_EN
                        else begin
                            tx_word <= hdr;
                        end
`endif
                    end else if (timed_out) begin
                        bus_req <= 1'b0;
                        state   <= ST_IDLE;
                        tx_word <= TIMEOUT_MARK | 32'(bus_addr);
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (err_inc),
        .value   (err_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ovr_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (ovr_inc),
        .value   (ovr_cnt)
    );

endmodule

// File: tb/tb_spi_cmd_sched.sv
// tb/tb_spi_cmd_sched.sv - scoreboard bench for spi_cmd_sched
module tb_spi_cmd_sched;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] rx_word = '0;
    logic        rx_rdy = 1'b0;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata = '0;
    logic [31:0] tx_word;
    logic        busy;
    logic [7:0]  err_cnt;
    logic [7:0]  ovr_cnt;

    logic        ack_r = 1'b0;
    logic        stray_ack = 1'b0;
    int          ack_delay = -1;
    int          ack_cnt = 0;
    logic [31:0] rdata_next = '0;
    bus_t        exp_q[$];
    int          cyc = 0;
    int          rx_cyc = 0;
    int          req_len = 0;
    logic        prev_req = 1'b0;
    int          n_vec = 0;
    int          n_mis = 0;
    bit          echo_en;

    assign bus_ack = ack_r | stray_ack;

    spi_cmd_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_word   (rx_word),
        .rx_rdy    (rx_rdy),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .tx_word   (tx_word),
        .busy      (busy),
        .err_cnt   (err_cnt),
        .ovr_cnt   (ovr_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus monitor and target model share one process so sampling precedes driving.
    initial forever begin
        bus_t e;
        @(negedge clk);
        if (ack_r) check("req_drop_after_ack", {31'b0, bus_req}, 32'd0);
        if (bus_req && !prev_req) begin
            req_len = 0;
            if (exp_q.size() == 0) begin
                check("spurious_req", {31'b0, bus_req}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("bus_we", {31'b0, bus_we}, {31'b0, e.we});
                check("bus_addr", {24'b0, bus_addr}, {24'b0, e.addr});
                if (e.we) check("bus_wdata", bus_wdata, e.wdata);
                check("req_latency", cyc - rx_cyc, 32'd2);
            end
        end
        if (bus_req) req_len++;
        prev_req = bus_req;
        if (ack_r) begin
            ack_r = 1'b0;
            ack_cnt = 0;
        end else if (bus_req) begin
            if (ack_delay >= 0 && ack_cnt == ack_delay) begin
                ack_r = 1'b1;
                bus_rdata = rdata_next;
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    task automatic send_word(input logic [31:0] w);
        @(negedge clk);
        rx_word = w;
        rx_rdy = 1'b1;
        rx_cyc = cyc;
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    task automatic push_bus(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
        bus_t e;
        e.we = we;
        e.addr = addr;
        e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || bus_req) && n < budget);
        if (n >= budget) check("idle_wait", {31'b0, busy}, 32'd0);
    endtask

    initial begin
`ifdef SPI_CMD_ECHO_EN
        echo_en = 1'b1;
`else
        echo_en = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("rst_bus_we", {31'b0, bus_we}, 32'd0);
        check("rst_bus_addr", {24'b0, bus_addr}, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_tx_word", tx_word, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check("rst_ovr_cnt", {24'b0, ovr_cnt}, 32'd0);
        reset_n = 1'b1;

        // WR_IMM with ack after 3 cycles
        ack_delay = 3;
        push_bus(1'b1, 8'h05, 32'h0001_2345);
        send_word(32'h1051_2345);
        wait_idle(50);
        check("wr_imm_tx", tx_word, echo_en ? 32'h1051_2345 : 32'h0);
        check("wr_imm_busy", {31'b0, busy}, 32'd0);

        // WR_LONG then RD back
        push_bus(1'b1, 8'h0A, 32'hCAFE_BABE);
        send_word(32'h20A0_0000);
        send_word(32'hCAFE_BABE);
        wait_idle(50);
        rdata_next = 32'hCAFE_BABE;
        push_bus(1'b0, 8'h0A, 32'h0);
        send_word(32'h30A0_0000);
        wait_idle(50);
        check("rd_tx", tx_word, 32'hCAFE_BABE);

        // ack in the last cycle before timeout wins
        ack_delay = 254;
        rdata_next = 32'h1234_5678;
        push_bus(1'b0, 8'h44, 32'h0);
        send_word(32'h3440_0000);
        wait_idle(400);
        check("late_ack_tx", tx_word, 32'h1234_5678);
        check("late_ack_err", {24'b0, err_cnt}, 32'd0);

        // timeout
        ack_delay = -1;
        push_bus(1'b0, 8'h33, 32'h0);
        send_word(32'h3330_0000);
        wait_idle(400);
        check("timeout_req_len", req_len, 32'd255);
        check("timeout_err", {24'b0, err_cnt}, 32'd1);
        check("timeout_tx", tx_word, 32'hDEAD_0033);

        // asynchronous reset in WAIT_ACK
        push_bus(1'b0, 8'h66, 32'h0);
        send_word(32'h3660_0000);
        for (int i = 0; i < 10 && !bus_req; i++) @(negedge clk);
        check("pre_reset_req", {31'b0, bus_req}, 32'd1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_bus_req", {31'b0, bus_req}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_tx", tx_word, 32'd0);
        check("arst_err", {24'b0, err_cnt}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_busy", {31'b0, busy}, 32'd0);
        check("stray_ack_tx", tx_word, 32'd0);

        // overrun, illegal opcode, STATUS
        ack_delay = 10;
        rdata_next = 32'h0BAD_F00D;
        push_bus(1'b0, 8'h20, 32'h0);
        send_word(32'h3200_0000);
        send_word(32'h1550_0000);
        wait_idle(50);
        check("ovr_rd_tx", tx_word, 32'h0BAD_F00D);
        check("ovr_cnt", {24'b0, ovr_cnt}, 32'd1);
        send_word(32'h7000_0000);
        check("illegal_err", {24'b0, err_cnt}, 32'd1);
        send_word(32'hF000_0000);
        check("status_tx", tx_word, 32'h0000_0101);

        // saturation then a short write
        for (int i = 0; i < 300; i++) send_word(32'h7000_0000);
        check("err_saturated", {24'b0, err_cnt}, 32'h0000_00FF);
        send_word(32'hF000_0000);
        check("status_sat_tx", tx_word, 32'h0000_01FF);
        ack_delay = 0;
        push_bus(1'b1, 8'h01, 32'h0000_0001);
        send_word(32'h1010_0001);
        wait_idle(50);
        check("echo_tx", tx_word, echo_en ? 32'h1010_0001 : 32'h0000_01FF);
        check("ovr_final", {24'b0, ovr_cnt}, 32'd1);
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
